btn_debounce_pulse: RTL and testbench
=====================================

Name: btn_debounce_pulse

Overview:
Input-conditioning stage that sits directly upstream of the game/VGA top level. It takes the raw, bouncing, asynchronous push-buttons (BtnL, BtnR, BtnU, BtnD, BtnC) and produces clean outputs for the block controller and the score logic:
- synchronized, debounced levels;
- single-cycle press and release pulses.

It runs on the 100 MHz ClkPort domain and has one independent FSM per button.

Parameters:
N_BTN, 5, number of buttons handled (bit i = button i, independent channels)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); legal range >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
REPEAT_DELAY, 50000000, cycles held before first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN)
REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses (used only with BTN_AUTOREPEAT_EN)

Ports:
ClkPort  input  1  system clock, 100 MHz, all logic rising-edge
Reset  input  1  asynchronous, active-high reset
btn_in  input  N_BTN  raw button pins, asynchronous, active-high
btn_level  output  N_BTN  debounced level, registered
btn_press  output  N_BTN  one-cycle pulse on accepted press (and on auto-repeat when enabled)
btn_release  output  N_BTN  one-cycle pulse on accepted release

Behaviour:
- Reset (Reset, asynchronous, active-high; clock ClkPort) clears the following immediately, independent of the clock:
  - all synchronizer flops, counters and FSM states (IDLE);
  - btn_level, btn_press and btn_release (all 0).
- Synchronizer: two flops per bit, btn_in -> s1 -> s2. All FSM decisions use s2 only.
- Per-channel FSM states: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE. Counter cnt[CNT_W-1:0].
- IDLE:
  - s2=1 -> WAIT_PRESS, cnt<=1;
  - else stay, cnt<=0.
- WAIT_PRESS:
  - s2=0 -> IDLE, cnt<=0 (bounce rejected, no pulse);
  - else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt<=0, btn_press<=1, btn_level<=1;
  - else cnt<=cnt+1.
- PRESSED:
  - s2=0 -> WAIT_RELEASE, cnt<=1;
  - else stay.
- WAIT_RELEASE:
  - s2=1 -> PRESSED, cnt<=0 (no pulse);
  - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_release<=1, btn_level<=0;
  - else cnt<=cnt+1.
- Pulse outputs are registered and default to 0 every cycle. Each is high for exactly one cycle per event.
- Latency: if edge k is the first edge sampling btn_in=1 into s1, and the input stays stable:
  - btn_press and btn_level go high after edge k+DEBOUNCE_CYCLES+1;
  - release is symmetric.
- Any glitch shorter than DEBOUNCE_CYCLES stable s2 samples produces no pulse and no level change.
- btn_press and btn_release are never high in the same cycle for one channel.
- Channels are fully independent. Simultaneous presses on several bits pulse in the same cycle if aligned.
- Reset mid-operation: all state is lost. If a button is still held after Reset deasserts, it is treated as a new press: a full debounce runs and one btn_press is generated.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined:
  - each channel has a repeat counter rcnt, cleared on entering PRESSED;
  - while in PRESSED with s2=1, rcnt increments;
  - at rcnt==REPEAT_DELAY-1 a btn_press pulse is issued, then one every REPEAT_PERIOD cycles while held;
  - leaving PRESSED (into WAIT_RELEASE) stops repeats and clears rcnt;
  - returning to PRESSED from WAIT_RELEASE restarts the delay from 0.
- Not defined: no repeat counter is built; exactly one btn_press per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=5, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: btn_in[1] rises before edge 10, held -> btn_press[1]=1 only after edge 15; btn_level[1]=1 from edge 15 on; other bits stay 0.
- Bounce rejection: btn_in[0] high 2 cycles, low 1, high 2, low -> no btn_press[0], btn_level[0] stays 0.
- Clean release: after the press, btn_in[1] falls before edge 40 -> btn_release[1] one cycle after edge 45; btn_level[1]=0 from edge 45.
- Simultaneous press: btn_in=5'b10100 before edge 10 -> btn_press=5'b10100 in the single cycle after edge 15.
- Reset mid-debounce: Reset asserted at edge 12 while btn_in[2] held, released at edge 20 -> outputs 0 during reset; btn_press[2] after edge 20+4+1+1 (first sample edge 21 -> pulse after edge 26).
- BTN_AUTOREPEAT_EN defined, btn_in[3] held -> btn_press[3] after edge 15, then 10 cycles later, then every 3 cycles until release.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_pulse
//  Description : Push-button conditioning. Each raw button is synchronised
//                with two flops, then debounced by its own four-state FSM
//                (IDLE / WAIT_PRESS / PRESSED / WAIT_RELEASE). The block
//                produces a registered debounced level and single-cycle
//                press and release pulses.
//                Optional macro BTN_AUTOREPEAT_EN adds a per-button repeat
//                timer. The timer re-issues btn_press while the button is
//                held.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] c_PRESSED      = 2'd2;
    localparam logic [1:0] c_WAIT_RELEASE = 2'd3;

    // The counter value on the final stable sample of a debounce window.
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_RCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RCNT_W   = $clog2(c_RCNT_MAX + 1);
    localparam logic [c_RCNT_W-1:0] c_DLY_LAST = c_RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RCNT_W-1:0] c_RPT_LAST = c_RCNT_W'(REPEAT_PERIOD - 1);
`endif

    // Reject configurations that cannot debounce or repeat correctly.
    if ((DEBOUNCE_CYCLES < 2) || (CNT_W < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
        ((CNT_W < 31) && ((1 << CNT_W) <= DEBOUNCE_CYCLES))) begin : g_cfg_check
        $error("btn_debounce_pulse: illegal parameter combination");
    end

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             w_level_nxt;
        logic             w_press_nxt;
        logic             w_release_nxt;
        logic             w_rep_pulse;
        logic             w_s2;

        assign w_s2 = r_s2[i];

        // State register, debounce counter and registered outputs
        always_ff @(posedge ClkPort or posedge Reset) begin
            if (Reset) begin
                r_state   <= c_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        // Next state: count consecutive samples that disagree with the accepted level
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                c_IDLE: begin
                    if (w_s2) begin
                        w_state_nxt = c_WAIT_PRESS;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                c_WAIT_PRESS: begin
                    if (!w_s2) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                c_PRESSED: begin
                    if (!w_s2) begin
                        w_state_nxt = c_WAIT_RELEASE;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                c_WAIT_RELEASE: begin
                    if (w_s2) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Output values: pulses fire only on the edge that accepts a change
        always_comb begin
            w_level_nxt   = r_level;
            w_press_nxt   = w_rep_pulse;
            w_release_nxt = 1'b0;
            if ((r_state == c_WAIT_PRESS) && w_s2 && (r_cnt == c_DEB_LAST)) begin
                w_press_nxt = 1'b1;
                w_level_nxt = 1'b1;
            end
            if ((r_state == c_WAIT_RELEASE) && !w_s2 && (r_cnt == c_DEB_LAST)) begin
                w_release_nxt = 1'b1;
                w_level_nxt   = 1'b0;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [c_RCNT_W-1:0] r_rcnt;
        logic                r_rep_phase;
        logic                w_holding;
        logic [c_RCNT_W-1:0] w_rep_last;

        // The first repeat waits the long delay; every later repeat uses the period.
        assign w_holding   = (r_state == c_PRESSED) && w_s2;
        assign w_rep_last  = r_rep_phase ? c_RPT_LAST : c_DLY_LAST;
        assign w_rep_pulse = w_holding && (r_rcnt == w_rep_last);

        // Repeat timer runs only while held in PRESSED and restarts on any exit
        always_ff @(posedge ClkPort or posedge Reset) begin
            if (Reset) begin
                r_rcnt      <= '0;
                r_rep_phase <= 1'b0;
            end else if (!w_holding) begin
                r_rcnt      <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_rep_pulse) begin
                r_rcnt      <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rcnt      <= r_rcnt + c_RCNT_W'(1);
            end
        end
`else
        assign w_rep_pulse = 1'b0;
`endif

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce_pulse
//  Description : Self-checking bench for btn_debounce_pulse. A run-length
//                model of the debounce rule is checked every cycle. Directed
//                scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_pulse;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         ClkPort = 1'b0;
    logic         Reset   = 1'b1;
    logic [N-1:0] btn_in  = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int n_cmp  = 0;
    int n_fail = 0;

    btn_debounce_pulse #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) u_dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: s2 is btn_in two edges late; the level flips once s2 has
    // disagreed with it on D consecutive edges.
    bit           m_s1    [N];
    bit           m_s2    [N];
    bit           m_level [N];
    int           m_run   [N];
    int           m_held  [N];
    logic [N-1:0] e_level;
    logic [N-1:0] e_press;
    logic [N-1:0] e_release;

    initial begin
        forever begin
            @(posedge ClkPort);
            #1;
            e_press   = '0;
            e_release = '0;
            for (int i = 0; i < N; i++) begin
                if (Reset) begin
                    m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_held[i] = 0;
                end else begin
                    bit x;
                    x = m_s2[i];
                    if (x != m_level[i]) begin
                        m_run[i]++;
                        m_held[i] = 0;
                        if (m_run[i] == D) begin
                            m_level[i] = x;
                            m_run[i]   = 0;
                            if (x) e_press[i] = 1'b1;
                            else   e_release[i] = 1'b1;
                        end
                    end else begin
                        if (m_level[i] && m_run[i] == 0) begin
                            m_held[i]++;
`ifdef BTN_AUTOREPEAT_EN
                            if (m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0) e_press[i] = 1'b1;
`endif
                        end
                        m_run[i] = 0;
                    end
                    m_s2[i] = m_s1[i];
                    m_s1[i] = btn_in[i];
                end
                e_level[i] = m_level[i];
            end
            check("model_level", btn_level, e_level);
            check("model_press", btn_press, e_press);
            check("model_release", btn_release, e_release);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge ClkPort);
        #2;
    endtask

    task automatic drive(input logic [N-1:0] v);
        @(negedge ClkPort);
        btn_in = v;
    endtask

    logic [N-1:0] bad;

    initial begin
        edges(3);
        @(negedge ClkPort);
        Reset = 1'b0;
        #1;
        check("reset_level", btn_level, '0);
        check("reset_press", btn_press, '0);
        check("reset_release", btn_release, '0);

        // Clean press on bit 1
        drive(5'b00010);
        edges(5);
        check("press_early", btn_press, '0);
        check("level_early", btn_level, '0);
        edges(1);
        check("press_b1", btn_press, 5'b00010);
        check("level_b1", btn_level, 5'b00010);
        edges(1);
        check("press_once", btn_press, '0);
        check("level_hold", btn_level, 5'b00010);

        // Bounce on bit 0: high 2, low 1, high 2, low
        drive(5'b00011); drive(5'b00011); drive(5'b00010);
        drive(5'b00011); drive(5'b00011); drive(5'b00010);
        bad = '0;
        for (int c = 0; c < 12; c++) begin
            edges(1);
            bad |= (btn_press | btn_level) & 5'b00001;
        end
        check("bounce_b0", bad, '0);

        // Clean release on bit 1
        drive(5'b00000);
        edges(5);
        check("release_early", btn_release, '0);
        check("level_before_rel", btn_level, 5'b00010);
        edges(1);
        check("release_b1", btn_release, 5'b00010);
        check("level_after_rel", btn_level, '0);
        edges(1);
        check("release_once", btn_release, '0);

        // Simultaneous press on bits 4 and 2
        drive(5'b10100);
        edges(5);
        check("simul_early", btn_press, '0);
        edges(1);
        check("simul_press", btn_press, 5'b10100);
        check("simul_level", btn_level, 5'b10100);
        drive(5'b00000);
        edges(10);
        check("simul_released", btn_level, '0);

        // Reset in the middle of a debounce on bit 2
        drive(5'b00100);
        edges(2);
        @(negedge ClkPort);
        Reset = 1'b1;
        #1;
        check("midrst_level", btn_level, '0);
        check("midrst_press", btn_press, '0);
        edges(8);
        @(negedge ClkPort);
        Reset = 1'b0;
        edges(5);
        check("postrst_early", btn_press, '0);
        edges(1);
        check("postrst_press", btn_press, 5'b00100);
        check("postrst_level", btn_level, 5'b00100);
        drive(5'b00000);
        edges(10);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat on bit 3
        drive(5'b01000);
        edges(6);
        check("rep_first", btn_press, 5'b01000);
        edges(9);
        check("rep_gap", btn_press, '0);
        edges(1);
        check("rep_delay", btn_press, 5'b01000);
        edges(2);
        check("rep_gap2", btn_press, '0);
        edges(1);
        check("rep_period", btn_press, 5'b01000);
        drive(5'b00000);
        edges(10);
`endif

        // Randomised bouncing inputs with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge ClkPort);
            if ($urandom_range(0, 599) == 0) Reset = 1'b1;
            else if (Reset && $urandom_range(0, 2) == 0) Reset = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) btn_in[i] = ~btn_in[i];
            end
        end
        @(negedge ClkPort);
        Reset  = 1'b0;
        btn_in = '0;
        edges(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
